// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - 31x32 register file with writeback source mux and commit counter
// Optional same-cycle write-through to read ports: define WB_REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WB_RegWrite,
    input  logic [1:0]       WB_MemtoReg,
    input  logic [31:0]      WB_ALUout,
    input  logic [31:0]      WB_MemReadData,
    input  logic [31:0]      WB_PCadd4,
    input  logic [4:0]       WB_rd,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic [31:0]      WB_WriteData,
    output logic [CNT_W-1:0] wb_count
);

    logic [31:0] regs [1:31];
    logic        commit;

    always_comb begin
        WB_WriteData = 32'h0;
        case (WB_MemtoReg)
            2'b00:   WB_WriteData = WB_ALUout;
            2'b01:   WB_WriteData = WB_MemReadData;
            2'b10:   WB_WriteData = WB_PCadd4;
            default: WB_WriteData = 32'h0;
        endcase
    end

    // Source 2'b11 is reserved: it neither writes nor counts.
    assign commit = WB_RegWrite && (WB_rd != 5'd0) && (WB_MemtoReg != 2'b11) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
            wb_count <= '0;
        end else if (commit) begin
            regs[WB_rd] <= WB_WriteData;
            wb_count    <= wb_count + CNT_W'(1);
        end
    end

    always_comb begin
        rs_data = 32'h0;
        if (!reset && (rs_addr != 5'd0)) begin
            rs_data = regs[rs_addr];
`ifdef WB_REGFILE_BYPASS_EN
            if (commit && (rs_addr == WB_rd)) begin
                rs_data = WB_WriteData;
            end
`endif
        end
    end

    always_comb begin
        rt_data = 32'h0;
        if (!reset && (rt_addr != 5'd0)) begin
            rt_data = regs[rt_addr];
`ifdef WB_REGFILE_BYPASS_EN
            if (commit && (rt_addr == WB_rd)) begin
                rt_data = WB_WriteData;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile against an array/counter reference model
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        WB_RegWrite;
    logic [1:0]  WB_MemtoReg;
    logic [31:0] WB_ALUout, WB_MemReadData, WB_PCadd4;
    logic [4:0]  WB_rd, rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data, WB_WriteData;
    logic [31:0] wb_count;
    logic [31:0] rs_data4, rt_data4, wd4;
    logic [3:0]  wb_count4;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mdl [32];
    int unsigned commits;

    always #5 clk = ~clk;

    wb_regfile #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
        .WB_ALUout(WB_ALUout), .WB_MemReadData(WB_MemReadData), .WB_PCadd4(WB_PCadd4),
        .WB_rd(WB_rd), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
        .rt_data(rt_data), .WB_WriteData(WB_WriteData), .wb_count(wb_count)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
        .WB_ALUout(WB_ALUout), .WB_MemReadData(WB_MemReadData), .WB_PCadd4(WB_PCadd4),
        .WB_rd(WB_rd), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data4),
        .rt_data(rt_data4), .WB_WriteData(wd4), .wb_count(wb_count4)
    );

    function automatic logic [31:0] exp_wd();
        case (WB_MemtoReg)
            2'b00:   return WB_ALUout;
            2'b01:   return WB_MemReadData;
            2'b10:   return WB_PCadd4;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit pending();
        return WB_RegWrite && WB_rd != 5'd0 && WB_MemtoReg != 2'b11 && !reset;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (reset || a == 5'd0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
        if (pending() && a == WB_rd) return exp_wd();
`endif
        return mdl[a];
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        commits = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wd"},     WB_WriteData, exp_wd());
        chk({tag, ".rs"},     rs_data,      exp_rd(rs_addr));
        chk({tag, ".rt"},     rt_data,      exp_rd(rt_addr));
        chk({tag, ".rs4"},    rs_data4,     exp_rd(rs_addr));
        chk({tag, ".cnt"},    wb_count,     commits);
        chk({tag, ".cnt4"},   {28'h0, wb_count4}, commits % 16);
    endtask

    task automatic drive(input logic we, input logic [1:0] sel, input logic [31:0] a,
                         input logic [31:0] m, input logic [31:0] p, input logic [4:0] d,
                         input logic [4:0] ra, input logic [4:0] rb);
        WB_RegWrite = we; WB_MemtoReg = sel; WB_ALUout = a; WB_MemReadData = m;
        WB_PCadd4 = p; WB_rd = d; rs_addr = ra; rt_addr = rb;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        if (pending()) begin
            mdl[WB_rd] = exp_wd();
            commits++;
        end
        #1;
    endtask

    task automatic rand_drive(input bit force_commit);
        logic [1:0] sel;
        logic [4:0] d;
        sel = 2'($urandom_range(0, 3));
        d   = 5'($urandom_range(0, 31));
        if (force_commit) begin
            sel = 2'($urandom_range(0, 2));
            d   = 5'($urandom_range(1, 31));
        end
        drive(force_commit ? 1'b1 : 1'($urandom), sel, $urandom, $urandom, $urandom, d,
              ($urandom_range(0, 3) == 0) ? d : 5'($urandom), 5'($urandom));
    endtask

    initial begin
        clear_model();
        reset = 1'b1;
        drive(1'b1, 2'b00, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd3, 5'd3, 5'd3);
        #1;
        for (int i = 0; i < 3; i++) cycle("in_reset");
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
            cycle("reset_read");
        end

        drive(1'b1, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
        cycle("wr5");
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
        @(negedge clk);
        chk("rd5_const", rs_data, 32'hDEADBEEF);
        chk("cnt1_const", wb_count, 32'd1);
        cycle("rd5");

        drive(1'b1, 2'b00, 32'h12345678, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5);
        cycle("wr0");
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        cycle("rd0");

        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'(s), 32'd1, 32'd2, 32'd3, 5'd7, 5'd7, 5'd5);
            cycle("sweep7");
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
        @(negedge clk);
        chk("reg7_const", rs_data, 32'd3);
        chk("cnt4_const", wb_count, 32'd4);
        cycle("rd7");

        for (int i = 0; i < 300; i++) begin
            rand_drive(1'b0);
            cycle("rand");
        end

        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 2'($urandom_range(0, 2)), $urandom, $urandom, $urandom, 5'(i),
                  5'(i), 5'($urandom));
            cycle("fill");
        end
        drive(1'b1, 2'b00, 32'hCAFEF00D, 32'h0, 32'h0, 5'd9, 5'd9, 5'd31);
        #2;
        reset = 1'b1;
        clear_model();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #2;
        reset = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd31);
        @(negedge clk);
        chk("dropped9", rs_data, 32'h0);
        cycle("post_rst");

        for (int i = 0; i < 17; i++) begin
            rand_drive(1'b1);
            cycle("wrap");
        end
        @(negedge clk);
        chk("wrap_cnt4", {28'h0, wb_count4}, 32'd1);
        chk("wrap_cnt32", wb_count, 32'd17);

        for (int i = 0; i < 200; i++) begin
            rand_drive(1'b0);
            cycle("rand2");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: CNT_W, default 32, width of the write-commit counter.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 WB_RegWrite  input  1  write enable from the WB stage.
REQ-005 WB_MemtoReg  input  2  writeback source select.
REQ-006 WB_ALUout  input  32  ALU result.
REQ-007 WB_MemReadData  input  32  load data.
REQ-008 WB_PCadd4  input  32  link address.
REQ-009 WB_rd  input  5  destination register index.
REQ-010 rs_addr  input  5  ID-stage read port A index.
REQ-011 rt_addr  input  5  ID-stage read port B index.
REQ-012 rs_data  output  32  read port A data.
REQ-013 rt_data  output  32  read port B data.
REQ-014 WB_WriteData  output  32  selected writeback value, combinational.
REQ-015 wb_count  output  CNT_W  number of committed register writes.

Function
REQ-016 Storage SHALL be 31 32-bit registers for indices 1..31; index 0 SHALL always read 32'h0 and never be written.
REQ-017 WB_WriteData SHALL be WB_ALUout for MemtoReg 2'b00, WB_MemReadData for 2'b01, WB_PCadd4 for 2'b10, and 32'h0 for 2'b11.
REQ-018 A commit SHALL occur on a rising clk edge when WB_RegWrite=1, WB_rd!=0, MemtoReg!=2'b11, and reset=0; the register at WB_rd SHALL take WB_WriteData.
REQ-019 MemtoReg=2'b11 with WB_RegWrite=1 SHALL be treated as reserved: no register write and no count increment.
REQ-020 Reads SHALL be combinational from rs_addr/rt_addr; a committed write SHALL be visible on read ports from the cycle after the commit edge.
REQ-021 wb_count SHALL increment by 1 on each commit and wrap from all-ones to 0; writes to index 0 SHALL NOT count.
REQ-022 rs_addr and rt_addr SHALL be allowed to be equal; both ports then return identical data.
REQ-023 Only one write port exists; no write arbitration is needed.

Reset
REQ-024 Asserting reset SHALL immediately clear registers 1..31 and wb_count to 0, independent of clk.
REQ-025 While reset is high, rs_data and rt_data SHALL read 0 for all indices and no commit SHALL occur.
REQ-026 A write pending at the edge on which reset deasserts SHALL be ignored only if reset is still sampled high at that edge.

Configuration
REQ-027 Macro WB_REGFILE_BYPASS_EN: when defined, a read port whose address equals WB_rd during a cycle in which a commit is pending (REQ-018 conditions, reset low) SHALL return WB_WriteData in that same cycle (write-through); index 0 still reads 0.
REQ-028 When WB_REGFILE_BYPASS_EN is not defined, read ports SHALL return stored contents only (REQ-020); ID-stage hazards are resolved by the stall logic.

Verification
REQ-029 Reset pulse, then read all 32 indices on both ports -> every read 32'h0, wb_count=0.
REQ-030 RegWrite=1, rd=5, MemtoReg=00, ALUout=32'hDEADBEEF; next cycle rs_addr=5 -> rs_data=32'hDEADBEEF, wb_count=1; with BYPASS_EN, rs_addr=5 in the write cycle also returns 32'hDEADBEEF, without it returns the old value 0.
REQ-031 Write rd=0 with ALUout=32'h12345678 -> index 0 reads 0, wb_count unchanged.
REQ-032 Sweep MemtoReg 00/01/10/11 to rd=7 with ALUout=1, MemReadData=2, PCadd4=3 -> reg7 reads 1, 2, 3, then stays 3; count advances by 3.
REQ-033 Assert reset asynchronously mid-cycle after writing regs 1..31 -> all outputs 0 before the next clk edge; the write presented during reset is dropped.
REQ-034 CNT_W=4, 17 commits -> wb_count=1 (wrap).
